uart_rx: RTL

UART receiver for 8N1 frames, the receive-direction counterpart of the transmitter on the same serial link. It synchronizes the asynchronous serial input into `i_Clock`, validates the start bit at mid-bit, and samples eight data bits LSB-first at bit centres using the configurable baud divider. It checks the stop bit and writes each good byte into the RX FIFO. Framing errors and FIFO overruns are flagged as single-cycle pulses.

---
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// Synchronises the serial line, qualifies the start bit at its mid-point,
// samples eight data bits LSB-first at bit centres, checks the stop bit and
// hands good bytes to the RX FIFO. Framing errors and FIFO overruns are
// reported as single-cycle pulses. CLKS_PER_BIT must be at least 4.

module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       rst,
    input  logic       i_RX_Serial,
    input  logic       full,
    output logic       wr_en,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_RX_Active,
    output logic       o_Frame_Err,
    output logic       o_Overrun
);

    // Counter is wide enough to hold CLKS_PER_BIT-1 with a spare bit.
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    // Half-bit offset: distance from the start edge to the start-bit centre.
    localparam int H     = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] H_CNT    = CNT_W'(H);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_WAIT_HIGH = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4,
        ST_CLEANUP   = 3'd5
    } state_t;

    // Synchronizer stages
    logic             rx_meta;
    logic             rx_sync;

    // Registered state and datapath
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_index_q, bit_index_d;
    logic [7:0]       data_q,      data_d;

    // Next values for the registered outputs
    logic [7:0]       rx_byte_d;
    logic             rx_dv_d;
    logic             wr_en_d;
    logic             frame_err_d;
    logic             overrun_d;
    logic             rx_active_d;

    // Two-flop synchronizer bringing the asynchronous serial line into i_Clock.
    // NOTE: both stages reset to 0 (not idle-high); WAIT_HIGH then requires
    // the line to be seen high before any frame can start, so the reset value
    // can never be mistaken for a start bit.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make rx_sync take the old rx_meta,
            // giving two real flop stages instead of a single collapsed one.
            rx_meta <= i_RX_Serial;
            rx_sync <= rx_meta;
        end
    end

    // State, counters, shift data and all outputs are registered here.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT_HIGH;
            cnt_q       <= '0;
            bit_index_q <= '0;
            data_q      <= '0;
            o_RX_Byte   <= '0;
            o_RX_DV     <= 1'b0;
            wr_en       <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Overrun   <= 1'b0;
            o_RX_Active <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_index_q <= bit_index_d;
            data_q      <= data_d;
            o_RX_Byte   <= rx_byte_d;
            o_RX_DV     <= rx_dv_d;
            wr_en       <= wr_en_d;
            o_Frame_Err <= frame_err_d;
            o_Overrun   <= overrun_d;
            o_RX_Active <= rx_active_d;
        end
    end

    // Next-state, counter, data and output-pulse logic for the receive FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case statement; any
        // path that leaves one unassigned would otherwise infer a latch.
        // The pulse defaults of 0 are what make DV/write/error one cycle long.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_index_d = bit_index_q;
        data_d      = data_q;
        rx_byte_d   = o_RX_Byte;
        rx_dv_d     = 1'b0;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            ST_WAIT_HIGH: begin
                // Line held low (reset or break): wait for a real idle level.
                if (rx_sync) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                cnt_d       = '0;
                bit_index_d = '0;
                if (!rx_sync) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q < H_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    // Still low at mid-start: a real start bit. High: a glitch.
                    state_d = rx_sync ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d               = '0;
                    data_d[bit_index_q] = rx_sync;
                    if (bit_index_q == 3'd7) begin
                        bit_index_d = '0;
                        state_d     = ST_STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d     = '0;
                    // The byte is published even for a bad frame, for debug.
                    rx_byte_d = data_q;
                    if (rx_sync) begin
                        rx_dv_d = 1'b1;
                        if (full) begin
                            overrun_d = 1'b1;
                        end else begin
                            wr_en_d = 1'b1;
                        end
                        state_d = ST_CLEANUP;
                    end else begin
                        // Stop bit low: framing error or break. Do not
                        // re-arm until the line has returned high.
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end

            ST_CLEANUP: begin
                // Pulses drop via the defaults; the stop bit's second half is
                // spent here and in IDLE, so back-to-back frames are caught.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_WAIT_HIGH;
            end
        endcase

        // Active reflects the state being entered so it is a clean flop output.
        rx_active_d = (state_d == ST_START) || (state_d == ST_DATA) ||
                      (state_d == ST_STOP);
    end

    // A frame is either a framing error or a good frame, never both.
    a_err_exclusive : assert property (
        @(posedge i_Clock) disable iff (rst) !(o_Frame_Err && o_Overrun)
    );

endmodule
